// File: rtl/qsys_led_timer_driver.sv
// Avalon-MM initiator for the LED interval timer. It programs the period, starts
// and stops the timer, services timeout interrupts and captures counter snapshots.
module qsys_led_timer_driver #(
  parameter int unsigned LED_WIDTH      = 8,
  parameter logic [31:0] DEFAULT_PERIOD = 32'd99999
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start_req,
  input  logic                 use_default,
  input  logic [31:0]          period_in,
  input  logic                 stop_req,
  input  logic                 snap_req,
  output logic                 ready,
  output logic                 running,
  output logic [31:0]          snap_value,
  output logic                 snap_valid,
  output logic [15:0]          tick_count,
  output logic [LED_WIDTH-1:0] led_out,
  output logic [2:0]           av_address,
  output logic                 av_chipselect,
  output logic                 av_write_n,
  output logic [15:0]          av_writedata,
  input  logic [15:0]          av_readdata,
  input  logic                 av_irq
);

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DATA_W = 16;

  localparam logic [ADDR_W-1:0] ADDR_STATUS = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_CTRL   = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_PER_L  = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_PER_H  = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_SNAP_L = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_SNAP_H = 3'd5;

  // Control word: ITO | CONT | START, and STOP alone.
  localparam logic [DATA_W-1:0] CTRL_START = 16'h0007;
  localparam logic [DATA_W-1:0] CTRL_STOP  = 16'h0008;

  typedef enum logic [3:0] {
    IDLE,
    WR_PL,
    WR_PH,
    WR_CTL,
    WR_STOP,
    WR_STAT,
    GAP,
    WR_SNAP,
    RD_L,
    RD_H,
    RD_END
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [31:0]        period_sel;
  logic [31:0]        period_q;
  logic [DATA_W-1:0]  snap_lo;

  logic [ADDR_W-1:0]  addr_nxt;
  logic               cs_nxt;
  logic               wn_nxt;
  logic [DATA_W-1:0]  wd_nxt;
  logic               start_go;

  assign period_sel = use_default ? DEFAULT_PERIOD : period_in;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state arbitration and the bus cycle to present in the next state.
  always_comb begin
    state_nxt = state;
    start_go  = 1'b0;
    addr_nxt  = '0;
    cs_nxt    = 1'b0;
    wn_nxt    = 1'b1;
    wd_nxt    = '0;

    case (state)
      IDLE: begin
        if (av_irq) begin
          state_nxt = WR_STAT;
        end else if (stop_req) begin
          state_nxt = WR_STOP;
        end else if (snap_req) begin
          state_nxt = WR_SNAP;
        end else if (start_req) begin
          state_nxt = WR_PL;
          start_go  = 1'b1;
        end
      end
      WR_PL:   state_nxt = WR_PH;
      WR_PH:   state_nxt = WR_CTL;
      WR_CTL:  state_nxt = IDLE;
      WR_STOP: state_nxt = IDLE;
      WR_STAT: state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      WR_SNAP: state_nxt = RD_L;
      RD_L:    state_nxt = RD_H;
      RD_H:    state_nxt = RD_END;
      RD_END:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    case (state_nxt)
      WR_PL: begin
        addr_nxt = ADDR_PER_L;
        cs_nxt   = 1'b1;
        wn_nxt   = 1'b0;
        wd_nxt   = period_sel[15:0];
      end
      WR_PH: begin
        addr_nxt = ADDR_PER_H;
        cs_nxt   = 1'b1;
        wn_nxt   = 1'b0;
        wd_nxt   = period_q[31:16];
      end
      WR_CTL: begin
        addr_nxt = ADDR_CTRL;
        cs_nxt   = 1'b1;
        wn_nxt   = 1'b0;
        wd_nxt   = CTRL_START;
      end
      WR_STOP: begin
        addr_nxt = ADDR_CTRL;
        cs_nxt   = 1'b1;
        wn_nxt   = 1'b0;
        wd_nxt   = CTRL_STOP;
      end
      WR_STAT: begin
        addr_nxt = ADDR_STATUS;
        cs_nxt   = 1'b1;
        wn_nxt   = 1'b0;
      end
      WR_SNAP: begin
        addr_nxt = ADDR_SNAP_L;
        cs_nxt   = 1'b1;
        wn_nxt   = 1'b0;
      end
      RD_L: begin
        addr_nxt = ADDR_SNAP_L;
        cs_nxt   = 1'b1;
      end
      RD_H: begin
        addr_nxt = ADDR_SNAP_H;
        cs_nxt   = 1'b1;
      end
      default: begin
        addr_nxt = '0;
      end
    endcase
  end

  // Registered bus outputs and ready, so every bus cycle lines up with its state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      av_address    <= '0;
      av_chipselect <= 1'b0;
      av_write_n    <= 1'b1;
      av_writedata  <= '0;
      ready         <= 1'b1;
    end else begin
      av_address    <= addr_nxt;
      av_chipselect <= cs_nxt;
      av_write_n    <= wn_nxt;
      av_writedata  <= wd_nxt;
      ready         <= (state_nxt == IDLE);
    end
  end

  // Hold the selected period so the upper half is still available in WR_PH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_q <= '0;
    end else if (start_go) begin
      period_q <= period_sel;
    end
  end

  // Running flag follows completion of the start and stop writes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      running <= 1'b0;
    end else if (state == WR_CTL) begin
      running <= 1'b1;
    end else if (state == WR_STOP) begin
      running <= 1'b0;
    end
  end

  // Each serviced timeout counts a tick and rotates the lit LED left.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_count <= '0;
      led_out    <= LED_WIDTH'(1);
    end else if (state == WR_STAT) begin
      tick_count <= 16'(tick_count + 16'd1);
      led_out    <= {led_out[LED_WIDTH-2:0], led_out[LED_WIDTH-1]};
    end
  end

  // Read data lags the read address by one cycle; the valid pulse accompanies the new value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap_lo    <= '0;
      snap_value <= '0;
      snap_valid <= 1'b0;
    end else begin
      snap_valid <= 1'b0;
      if (state == RD_H) begin
        snap_lo <= av_readdata;
      end
      if (state == RD_END) begin
        snap_value <= {av_readdata, snap_lo};
        snap_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_qsys_led_timer_driver.sv
// Randomized scoreboard bench for qsys_led_timer_driver with a behavioural timer slave.
module tb_qsys_led_timer_driver;

  localparam int unsigned LW = 8;
  localparam logic [31:0] DEF_PERIOD = 32'd99999;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start_req = 1'b0;
  logic          use_default = 1'b0;
  logic [31:0]   period_in = '0;
  logic          stop_req = 1'b0;
  logic          snap_req = 1'b0;
  logic          ready;
  logic          running;
  logic [31:0]   snap_value;
  logic          snap_valid;
  logic [15:0]   tick_count;
  logic [LW-1:0] led_out;
  logic [2:0]    av_address;
  logic          av_chipselect;
  logic          av_write_n;
  logic [15:0]   av_writedata;
  logic [15:0]   av_readdata = '0;
  logic          av_irq = 1'b0;

  logic          irq_raise = 1'b0;
  logic [31:0]   next_snap = '0;
  logic [31:0]   snap_reg = '0;

  int total = 0;
  int bad = 0;

  // Expected bus cycles as {is_write, address, write data (0 for reads)}.
  logic [19:0] bus_q[$];
  logic [31:0] snap_q[$];

  // Reference model state.
  int m_ticks = 0;
  bit m_running = 1'b0;

  qsys_led_timer_driver #(.LED_WIDTH(LW), .DEFAULT_PERIOD(DEF_PERIOD)) dut (
    .clk(clk), .reset_n(reset_n), .start_req(start_req), .use_default(use_default),
    .period_in(period_in), .stop_req(stop_req), .snap_req(snap_req), .ready(ready),
    .running(running), .snap_value(snap_value), .snap_valid(snap_valid),
    .tick_count(tick_count), .led_out(led_out), .av_address(av_address),
    .av_chipselect(av_chipselect), .av_write_n(av_write_n), .av_writedata(av_writedata),
    .av_readdata(av_readdata), .av_irq(av_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [LW-1:0] led_exp(input int t);
    logic [LW-1:0] v;
    v = LW'(1);
    return v << (t % LW);
  endfunction

  // Timer slave: irq cleared by status write, snapshot latched by addr4 write, 1-cycle read latency.
  always @(posedge clk) begin
    if (av_chipselect && !av_write_n && av_address == 3'd0) av_irq <= 1'b0;
    else if (irq_raise) av_irq <= 1'b1;
    if (av_chipselect && !av_write_n && av_address == 3'd4) snap_reg <= next_snap;
    if (av_chipselect && av_write_n) begin
      case (av_address)
        3'd4:    av_readdata <= snap_reg[15:0];
        3'd5:    av_readdata <= snap_reg[31:16];
        default: av_readdata <= 16'h0000;
      endcase
    end
  end

  // Monitor: pop and compare every bus cycle and snapshot pulse the DUT presents.
  bit prev_stat = 1'b0;
  logic [19:0] bus_e;
  logic [19:0] bus_a;
  logic [31:0] snap_e;
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stat <= 1'b0;
    end else begin
      if (prev_stat) check("gap_after_status", 32'(av_chipselect), 32'd0);
      if (av_chipselect) begin
        bus_a = {~av_write_n, av_address, av_write_n ? 16'h0000 : av_writedata};
        if (bus_q.size() == 0) begin
          check("unexpected_bus", 32'(bus_a), 32'hFFFFFFFF);
        end else begin
          bus_e = bus_q.pop_front();
          check("bus_cycle", 32'(bus_a), 32'(bus_e));
        end
      end else begin
        check("idle_write_n", 32'(av_write_n), 32'd1);
      end
      prev_stat <= av_chipselect && !av_write_n && (av_address == 3'd0);
      if (snap_valid) begin
        if (snap_q.size() == 0) begin
          check("unexpected_snap", snap_value, 32'hxxxxxxxx);
        end else begin
          snap_e = snap_q.pop_front();
          check("snap_value", snap_value, snap_e);
        end
      end
    end
  end

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_return", 32'(ready), 32'd1);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_running"}, 32'(running), 32'(m_running));
    check({tag, "_ticks"}, 32'(tick_count), 32'(16'(m_ticks)));
    check({tag, "_led"}, 32'(led_out), 32'(led_exp(m_ticks)));
  endtask

  task automatic do_start(input bit ud, input logic [31:0] p, output int n);
    logic [31:0] eff;
    eff = ud ? DEF_PERIOD : p;
    bus_q.push_back({1'b1, 3'd2, eff[15:0]});
    bus_q.push_back({1'b1, 3'd3, eff[31:16]});
    bus_q.push_back({1'b1, 3'd1, 16'h0007});
    use_default = ud; period_in = p; start_req = 1'b1;
    @(posedge clk); #1;
    start_req = 1'b0; use_default = 1'($urandom); period_in = $urandom;
    wait_ready(n);
    m_running = 1'b1;
    check_state("start");
  endtask

  task automatic do_stop(output int n);
    bus_q.push_back({1'b1, 3'd1, 16'h0008});
    stop_req = 1'b1;
    @(posedge clk); #1;
    stop_req = 1'b0;
    wait_ready(n);
    m_running = 1'b0;
    check_state("stop");
  endtask

  task automatic do_snap(input logic [31:0] val, output int n);
    next_snap = val;
    bus_q.push_back({1'b1, 3'd4, 16'h0000});
    bus_q.push_back({1'b0, 3'd4, 16'h0000});
    bus_q.push_back({1'b0, 3'd5, 16'h0000});
    snap_q.push_back(val);
    snap_req = 1'b1;
    @(posedge clk); #1;
    snap_req = 1'b0;
    wait_ready(n);
    check("snap_latency", 32'(n), 32'd4);
    check("snap_valid_pulse", 32'(snap_valid), 32'd1);
    @(posedge clk); #1;
    check("snap_valid_one_cycle", 32'(snap_valid), 32'd0);
    check_state("snap");
  endtask

  task automatic do_irq(output int n);
    bus_q.push_back({1'b1, 3'd0, 16'h0000});
    irq_raise = 1'b1;
    @(posedge clk); #1;
    irq_raise = 1'b0;
    @(posedge clk); #1;
    wait_ready(n);
    m_ticks++;
    check_state("irq");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_running", 32'(running), 32'd0);
    check("rst_ticks", 32'(tick_count), 32'd0);
    check("rst_led", 32'(led_out), 32'd1);
    check("rst_snap", snap_value, 32'd0);
    check("rst_snap_valid", 32'(snap_valid), 32'd0);
    check("rst_cs", 32'(av_chipselect), 32'd0);
    check("rst_wn", 32'(av_write_n), 32'd1);
    check("rst_addr", 32'(av_address), 32'd0);
    check("rst_wd", 32'(av_writedata), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    do_start(1'b1, 32'h0, n);
    check("start_ready_low", 32'(n), 32'd3);

    for (int i = 0; i < 9; i++) begin
      do_irq(n);
      check("irq_ready_low", 32'(n), 32'd2);
    end
    check("nine_ticks", 32'(tick_count), 32'd9);
    check("nine_led", 32'(led_out), 32'h02);

    // irq and stop in the same idle cycle: stop is dropped.
    bus_q.push_back({1'b1, 3'd0, 16'h0000});
    irq_raise = 1'b1;
    @(posedge clk); #1;
    irq_raise = 1'b0; stop_req = 1'b1;
    @(posedge clk); #1;
    stop_req = 1'b0;
    wait_ready(n);
    m_ticks++;
    check_state("collide");
    check("collide_running", 32'(running), 32'd1);

    do_snap(32'h00011234, n);
    check("snap_directed", snap_value, 32'h00011234);

    do_stop(n);
    check("stop_running", 32'(running), 32'd0);
    do_start(1'b0, 32'h000A0005, n);
    do_stop(n);

    // Reset during WR_PH: only the low-period write is ever seen.
    bus_q.push_back({1'b1, 3'd2, 16'h1111});
    period_in = 32'h22221111; use_default = 1'b0; start_req = 1'b1;
    @(posedge clk); #1;
    start_req = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_addr", 32'(av_address), 32'd3);
    reset_n = 1'b0;
    #1;
    check("mid_rst_cs", 32'(av_chipselect), 32'd0);
    check("mid_rst_wn", 32'(av_write_n), 32'd1);
    check("mid_rst_ready", 32'(ready), 32'd1);
    check("mid_rst_ticks", 32'(tick_count), 32'd0);
    check("mid_rst_led", 32'(led_out), 32'd1);
    check("mid_rst_snap", snap_value, 32'd0);
    m_ticks = 0; m_running = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_state("post_rst");

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: do_start(1'($urandom), $urandom, n);
        1: do_stop(n);
        2: do_snap($urandom, n);
        default: do_irq(n);
      endcase
    end

    repeat (3) @(posedge clk);
    #1;
    check("bus_queue_empty", 32'(bus_q.size()), 32'd0);
    check("snap_queue_empty", 32'(snap_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
